// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory stage and MEM/WB pipeline register of the vector ASIP.
// Issues loads/stores over a variable-latency ready handshake, stalls the
// upstream EX/MEM register while an access is outstanding and registers the
// write-back value, write enable and destination register.
// Optional feature macro: MEM_TIMEOUT_EN (abort a WAIT after TIMEOUT cycles,
// raise sticky Error_o). Without it WAIT persists and Error_o is tied low.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepting a new op; ALU ops pass through, memory ops issue
// WAIT  | memory access outstanding, request driven from latched copy
module mem_wb_stage #(
  parameter int N       = 32,
  parameter int AW      = 10,
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [N-1:0]  RD2_i,
  input  logic          RF_WE_i,
  input  logic          MemWE_i,
  input  logic          WBSelect_i,
  input  logic [N-1:0]  AluResult_i,
  input  logic [3:0]    A3_i,
  output logic          Stall_o,
  output logic          MemReq_o,
  output logic          MemWrite_o,
  output logic [AW-1:0] MemAddr_o,
  output logic [N-1:0]  MemWData_o,
  input  logic [N-1:0]  MemRData_i,
  input  logic          MemReady_i,
  output logic [N-1:0]  Result_o,
  output logic          RF_WE_o,
  output logic [3:0]    A3_o,
  output logic          Error_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic [0:0]   state;
  logic [N-1:0] alu_q;
  logic [N-1:0] wdata_q;
  logic         write_q;
  logic         rf_we_q;
  logic [3:0]   a3_q;
  logic [CW-1:0] cnt;
  logic         mem_op;
  logic         in_wait;
  logic         expire;

  assign mem_op  = MemWE_i | WBSelect_i;
  assign in_wait = (state == S_WAIT);
  // Ready in the expiry cycle wins, so expiry needs ready low.
  assign expire  = TO_EN && in_wait && !MemReady_i && (cnt == CW'(TIMEOUT - 1));

  // Memory request and stall: from inputs in IDLE, from the latched copy in WAIT.
  always_comb begin
    MemReq_o   = 1'b0;
    MemWrite_o = 1'b0;
    Stall_o    = 1'b0;
    MemAddr_o  = AluResult_i[AW-1:0];
    MemWData_o = RD2_i;
    if (in_wait) begin
      MemAddr_o  = alu_q[AW-1:0];
      MemWData_o = wdata_q;
    end
    if (!RST) begin
      if (in_wait) begin
        MemReq_o   = 1'b1;
        MemWrite_o = write_q;
        Stall_o    = !MemReady_i && !expire;
      end else if (mem_op) begin
        MemReq_o   = 1'b1;
        MemWrite_o = MemWE_i;
        Stall_o    = !MemReady_i;
      end
    end
  end

  // FSM and MEM/WB output register; stalled cycles write a bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      Result_o <= '0;
      RF_WE_o  <= 1'b0;
      A3_o     <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!mem_op) begin
            Result_o <= AluResult_i;
            RF_WE_o  <= RF_WE_i;
            A3_o     <= A3_i;
          end else if (MemReady_i) begin
            Result_o <= MemWE_i ? AluResult_i : MemRData_i;
            RF_WE_o  <= !MemWE_i && RF_WE_i;
            A3_o     <= A3_i;
          end else begin
            RF_WE_o <= 1'b0;
            state   <= S_WAIT;
          end
        end
        default: begin
          if (MemReady_i) begin
            Result_o <= write_q ? alu_q : MemRData_i;
            RF_WE_o  <= !write_q && rf_we_q;
            A3_o     <= a3_q;
            state    <= S_IDLE;
          end else begin
            RF_WE_o <= 1'b0;
            if (expire) state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Capture the request fields whenever a memory op is presented in IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rf_we_q <= 1'b0;
      a3_q    <= 4'd0;
    end else if (!in_wait && mem_op) begin
      alu_q   <= AluResult_i;
      wdata_q <= RD2_i;
      write_q <= MemWE_i;
      rf_we_q <= RF_WE_i;
      a3_q    <= A3_i;
    end
  end

  // WAIT-cycle counter; held at zero in IDLE so it starts clean on entry.
  always_ff @(posedge CLK) begin
    if (RST || !in_wait) cnt <= '0;
    else                 cnt <= cnt + CW'(1);
  end

`ifdef MEM_TIMEOUT_EN
  logic err_q;

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST)         err_q <= 1'b0;
    else if (expire) err_q <= 1'b1;
  end

  assign Error_o = err_q;
`else
  assign Error_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scenarios followed by a randomized instruction
// stream checked against a transaction-level memory/pipeline model.
module tb_mem_wb_stage;
  localparam int N  = 32;
  localparam int AW = 10;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  RD2_i;
  logic          RF_WE_i;
  logic          MemWE_i;
  logic          WBSelect_i;
  logic [N-1:0]  AluResult_i;
  logic [3:0]    A3_i;
  logic          Stall_o;
  logic          MemReq_o;
  logic          MemWrite_o;
  logic [AW-1:0] MemAddr_o;
  logic [N-1:0]  MemWData_o;
  logic [N-1:0]  MemRData_i;
  logic          MemReady_i;
  logic [N-1:0]  Result_o;
  logic          RF_WE_o;
  logic [3:0]    A3_o;
  logic          Error_o;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_wb_stage #(.N(N), .AW(AW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .RD2_i(RD2_i), .RF_WE_i(RF_WE_i), .MemWE_i(MemWE_i),
    .WBSelect_i(WBSelect_i), .AluResult_i(AluResult_i), .A3_i(A3_i),
    .Stall_o(Stall_o), .MemReq_o(MemReq_o), .MemWrite_o(MemWrite_o),
    .MemAddr_o(MemAddr_o), .MemWData_o(MemWData_o), .MemRData_i(MemRData_i),
    .MemReady_i(MemReady_i), .Result_o(Result_o), .RF_WE_o(RF_WE_o),
    .A3_o(A3_o), .Error_o(Error_o)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic wb, input logic rfwe,
                       input logic [N-1:0] alu, input logic [N-1:0] rd2,
                       input logic [3:0] a3, input logic rdy, input logic [N-1:0] rdata);
    MemWE_i = we; WBSelect_i = wb; RF_WE_i = rfwe; AluResult_i = alu;
    RD2_i = rd2; A3_i = a3; MemReady_i = rdy; MemRData_i = rdata;
  endtask

  task automatic edge_settle();
    @(posedge CLK); #1;
  endtask

  logic [N-1:0] mem [16];
  logic [N-1:0] r_alu, r_wd;
  logic [3:0]   r_a3;
  logic         r_we, r_wb, r_rfwe;
  int           r_op, r_lat, r_idx;

  initial begin
    // ---- reset: outputs cleared, request/stall forced low ----
    RST = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h44, 32'h99, 4'hA, 1'b1, 32'h0);
    @(negedge CLK);
    chk("rst_memreq", MemReq_o, 0);
    chk("rst_stall", Stall_o, 0);
    chk("rst_memwrite", MemWrite_o, 0);
    edge_settle();
    chk("rst_result", Result_o, 0);
    chk("rst_rfwe", RF_WE_o, 0);
    chk("rst_a3", A3_o, 0);
    chk("rst_error", Error_o, 0);
    RST = 1'b0;

    // ---- ALU pass-through ----
    drive(1'b0, 1'b0, 1'b1, 32'h4, 32'h0, 4'd3, 1'b0, 32'h0);
    @(negedge CLK);
    chk("alu_stall", Stall_o, 0);
    chk("alu_req", MemReq_o, 0);
    edge_settle();
    chk("alu_result", Result_o, 32'h4);
    chk("alu_rfwe", RF_WE_o, 1);
    chk("alu_a3", A3_o, 3);

    // ---- zero-wait load ----
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 4'd5, 1'b1, 32'hDEADBEEF);
    @(negedge CLK);
    chk("zw_req", MemReq_o, 1);
    chk("zw_addr", MemAddr_o, 32'h10);
    chk("zw_write", MemWrite_o, 0);
    chk("zw_stall", Stall_o, 0);
    edge_settle();
    chk("zw_result", Result_o, 32'hDEADBEEF);
    chk("zw_rfwe", RF_WE_o, 1);
    chk("zw_a3", A3_o, 5);

    // ---- 3-wait store; inputs scrambled during WAIT to prove the latched copy ----
    drive(1'b1, 1'b0, 1'b1, 32'h20, 32'h3, 4'd7, 1'b0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      MemReady_i = (c == 3);
      @(negedge CLK);
      chk("st_stall", Stall_o, (c < 3));
      chk("st_req", MemReq_o, 1);
      chk("st_write", MemWrite_o, 1);
      chk("st_addr", MemAddr_o, 32'h20);
      chk("st_wdata", MemWData_o, 32'h3);
      edge_settle();
      chk("st_rfwe", RF_WE_o, 0);
      if (c == 0) begin
        RD2_i = 32'hBAD;
        AluResult_i = 32'h3FF;
      end
    end
    chk("st_a3", A3_o, 7);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0);
    @(negedge CLK);
    chk("st_idle_req", MemReq_o, 0);
    chk("st_idle_stall", Stall_o, 0);
    edge_settle();

    // ---- load with one wait, then ALU op back-to-back ----
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h0, 4'd9, 1'b0, 32'h0);
    @(negedge CLK);
    chk("la_stall0", Stall_o, 1);
    edge_settle();
    chk("la_bubble", RF_WE_o, 0);
    MemReady_i = 1'b1;
    MemRData_i = 32'h12345678;
    @(negedge CLK);
    chk("la_stall1", Stall_o, 0);
    edge_settle();
    chk("la_result", Result_o, 32'h12345678);
    chk("la_rfwe", RF_WE_o, 1);
    chk("la_a3", A3_o, 9);
    drive(1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 4'd2, 1'b0, 32'h0);
    @(negedge CLK);
    chk("la_alu_req", MemReq_o, 0);
    chk("la_alu_stall", Stall_o, 0);
    edge_settle();
    chk("la_alu_result", Result_o, 32'h55);
    chk("la_alu_rfwe", RF_WE_o, 1);
    chk("la_alu_a3", A3_o, 2);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0);
    edge_settle();
    chk("la_nodup", RF_WE_o, 0);

    // ---- reset during the second WAIT cycle of a load ----
    drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 4'd6, 1'b0, 32'h0);
    edge_settle();
    edge_settle();
    RST = 1'b1;
    @(negedge CLK);
    chk("rw_req_in_rst", MemReq_o, 0);
    chk("rw_stall_in_rst", Stall_o, 0);
    edge_settle();
    RST = 1'b0;
    chk("rw_rfwe", RF_WE_o, 0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1, 32'hCAFE);
    @(negedge CLK);
    chk("rw_req", MemReq_o, 0);
    chk("rw_stall", Stall_o, 0);
    edge_settle();
    chk("rw_nowb_rfwe", RF_WE_o, 0);
    chk("rw_nowb_result", Result_o, 0);

    // ---- randomized instruction stream against a transaction model ----
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int t = 0; t < 200; t++) begin
      r_op   = $urandom_range(0, 3);
      r_lat  = $urandom_range(0, 3);
      r_alu  = $urandom & 32'hFFFF_FC0F;
      r_wd   = $urandom;
      r_a3   = 4'($urandom_range(0, 15));
      r_rfwe = 1'($urandom_range(0, 1));
      r_we   = (r_op >= 2);
      r_wb   = (r_op == 1) || (r_op == 3);
      r_idx  = int'(r_alu % 16);
      if (r_op == 0) begin
        drive(1'b0, 1'b0, r_rfwe, r_alu, r_wd, r_a3, 1'($urandom_range(0, 1)), $urandom);
        @(negedge CLK);
        chk("r_alu_stall", Stall_o, 0);
        chk("r_alu_req", MemReq_o, 0);
        edge_settle();
        chk("r_alu_result", Result_o, r_alu);
        chk("r_alu_rfwe", RF_WE_o, r_rfwe);
        chk("r_alu_a3", A3_o, r_a3);
      end else begin
        drive(r_we, r_wb, r_rfwe, r_alu, r_wd, r_a3, 1'b0, 32'h0);
        for (int c = 0; c <= r_lat; c++) begin
          MemReady_i = (c == r_lat);
          MemRData_i = ((c == r_lat) && !r_we) ? mem[r_idx] : $urandom;
          @(negedge CLK);
          chk("r_mem_req", MemReq_o, 1);
          chk("r_mem_write", MemWrite_o, r_we);
          chk("r_mem_addr", MemAddr_o, r_alu % 1024);
          chk("r_mem_stall", Stall_o, (c != r_lat));
          if (r_we) chk("r_mem_wdata", MemWData_o, r_wd);
          edge_settle();
          if (c < r_lat) begin
            chk("r_mem_bubble", RF_WE_o, 0);
            AluResult_i = $urandom;
            RD2_i = $urandom;
          end else if (r_we) begin
            chk("r_st_rfwe", RF_WE_o, 0);
            chk("r_st_a3", A3_o, r_a3);
            mem[r_idx] = r_wd;
          end else begin
            chk("r_ld_result", Result_o, mem[r_idx]);
            chk("r_ld_rfwe", RF_WE_o, r_rfwe);
            chk("r_ld_a3", A3_o, r_a3);
          end
        end
      end
    end

`ifdef MEM_TIMEOUT_EN
    // ---- timeout: ready never arrives ----
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0);
    edge_settle();
    RST = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 32'h50, 32'h0, 4'd4, 1'b0, 32'h0);
    for (int c = 0; c <= TO; c++) begin
      @(negedge CLK);
      chk("to_stall", Stall_o, (c < TO));
      chk("to_req", MemReq_o, 1);
      edge_settle();
      chk("to_rfwe", RF_WE_o, 0);
      chk("to_error", Error_o, (c == TO));
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0);
    @(negedge CLK);
    chk("to_req_dropped", MemReq_o, 0);
    chk("to_stall_released", Stall_o, 0);
    for (int k = 0; k < 3; k++) begin
      edge_settle();
      chk("to_error_sticky", Error_o, 1);
    end
    RST = 1'b1;
    edge_settle();
    RST = 1'b0;
    chk("to_error_cleared", Error_o, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
